// File: rtl/seq_multiplier_if.sv
// Start/operand/result bundle between the HI/LO issue logic and the sequential multiplier.
interface seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic             go;
   logic             is_signed;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output go, is_signed, multiplicand, multiplier,
      input  busy, done, hi, lo
   );

   modport slave (
      input  go, is_signed, multiplicand, multiplier,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier for MULT/MULTU: magnitudes are multiplied one bit per cycle,
// the sign is applied in FIX, and an optional early exit skips trailing zero multiplier bits.
module seq_multiplier #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input logic             CLK,
   input logic             reset,
   seq_multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [PW-1:0]    p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [CW-1:0]    rem;
   logic [WIDTH-1:0] low_mask;
   logic             et_hit;
   logic [WIDTH:0]   upper;
   logic [PW-1:0]    iter_p;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
      return neg ? ((~p) + (2*WIDTH)'(1)) : p;
   endfunction

   // Early exit once every multiplier bit not yet consumed is zero; rem bits remain.
   always_comb begin
      rem      = CW'(WIDTH) - cnt_q;
      low_mask = ~({WIDTH{1'b1}} << rem);
      et_hit   = EARLY_TERM && ((p_q[WIDTH-1:0] & low_mask) == '0);
      upper    = p_q[PW-1:WIDTH] + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      iter_p   = {upper, p_q[WIDTH-1:0]} >> 1;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.go) begin
               a_d     = magnitude(bus.multiplicand, bus.is_signed);
               p_d     = {{(WIDTH+1){1'b0}}, magnitude(bus.multiplier, bus.is_signed)};
               cnt_d   = '0;
               neg_d   = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (et_hit) begin
               p_d     = p_q >> rem;
               state_d = FIX;
            end else begin
               p_d   = iter_p;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
         end
         FIX: begin
            {hi_d, lo_d} = apply_sign(p_q[2*WIDTH-1:0], neg_q);
            state_d      = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge CLK) begin
      a_q   <= a_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
   end

   assign bus.busy = (state_q == RUN) || (state_q == FIX);
   assign bus.done = (state_q == DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 8-bit instances with and without early exit, 32-bit instances
// against a 64-bit reference product.
module tb_seq_multiplier;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_multiplier_if #(.WIDTH(8))  b8n ();
   seq_multiplier_if #(.WIDTH(8))  b8e ();
   seq_multiplier_if #(.WIDTH(32)) b32n ();
   seq_multiplier_if #(.WIDTH(32)) b32e ();

   seq_multiplier #(.WIDTH(8),  .EARLY_TERM(1'b0)) u8n  (.CLK(clk), .reset(rst_n), .bus(b8n));
   seq_multiplier #(.WIDTH(8),  .EARLY_TERM(1'b1)) u8e  (.CLK(clk), .reset(rst_n), .bus(b8e));
   seq_multiplier #(.WIDTH(32), .EARLY_TERM(1'b0)) u32n (.CLK(clk), .reset(rst_n), .bus(b32n));
   seq_multiplier #(.WIDTH(32), .EARLY_TERM(1'b1)) u32e (.CLK(clk), .reset(rst_n), .bus(b32e));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // id 0: 8-bit no early exit, 1: 8-bit early exit, 2: 32-bit no early exit, 3: 32-bit early exit
   task automatic set_in(input int id, input logic g, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
      case (id)
         0: begin b8n.go = g;  b8n.is_signed = s;  b8n.multiplicand = a[7:0];  b8n.multiplier = b[7:0];  end
         1: begin b8e.go = g;  b8e.is_signed = s;  b8e.multiplicand = a[7:0];  b8e.multiplier = b[7:0];  end
         2: begin b32n.go = g; b32n.is_signed = s; b32n.multiplicand = a;      b32n.multiplier = b;      end
         default: begin b32e.go = g; b32e.is_signed = s; b32e.multiplicand = a; b32e.multiplier = b;     end
      endcase
   endtask

   task automatic get_out(input int id, output logic bz, output logic dn, output logic [63:0] pr);
      case (id)
         0: begin bz = b8n.busy;  dn = b8n.done;  pr = {48'h0, b8n.hi, b8n.lo};  end
         1: begin bz = b8e.busy;  dn = b8e.done;  pr = {48'h0, b8e.hi, b8e.lo};  end
         2: begin bz = b32n.busy; dn = b32n.done; pr = {b32n.hi, b32n.lo};       end
         default: begin bz = b32e.busy; dn = b32e.done; pr = {b32e.hi, b32e.lo}; end
      endcase
   endtask

   // Drives go for one edge; returns observing cycle 1.
   task automatic start(input int id, input logic s, input logic [31:0] a, input logic [31:0] b);
      set_in(id, 1'b1, s, a, b);
      tick();
      set_in(id, 1'b0, s, a, b);
   endtask

   // Stops in the DONE cycle; cyc = -1 if done never arrives within the budget.
   task automatic wait_done(input int id, input int c0, output int cyc, output logic [63:0] prod);
      logic bz, dn;
      logic [63:0] pr;
      cyc  = -1;
      prod = 'x;
      for (int c = c0; c <= c0 + 80; c++) begin
         get_out(id, bz, dn, pr);
         if (dn) begin
            cyc  = c;
            prod = pr;
            break;
         end
         tick();
      end
   endtask

   task automatic mul(input int id, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp_p, input int exp_c, input string tag);
      int          cyc;
      logic [63:0] prod;
      start(id, s, a, b);
      wait_done(id, 1, cyc, prod);
      check({tag, "_prod"}, prod, exp_p);
      if (exp_c >= 0) check({tag, "_cycle"}, 64'(cyc), 64'(exp_c));
      tick();
   endtask

   function automatic logic [63:0] ref64(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return 64'(sa * sb);
      end
      return {32'h0, a} * {32'h0, b};
   endfunction

   initial begin
      logic        bz, dn, any_done;
      logic [63:0] pr;
      int          cyc;
      logic [31:0] ra, rb;
      logic        rs;

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) set_in(i, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      get_out(0, bz, dn, pr);
      check("rst_busy8", 64'(bz), 64'd0);
      check("rst_done8", 64'(dn), 64'd0);
      check("rst_prod8", pr, 64'h0);
      get_out(3, bz, dn, pr);
      check("rst_busy32", 64'(bz), 64'd0);
      check("rst_prod32", pr, 64'h0);
      rst_n = 1'b1;
      tick();

      // Full-length run: busy in cycles 1-9, done only in cycle 10.
      start(0, 1'b0, 32'd13, 32'd11);
      for (int c = 1; c <= 11; c++) begin
         get_out(0, bz, dn, pr);
         check($sformatf("t1_busy_c%0d", c), 64'(bz), 64'(c <= 9));
         check($sformatf("t1_done_c%0d", c), 64'(dn), 64'(c == 10));
         if (c == 10) check("t1_prod", pr, 64'h008F);
         tick();
      end

      mul(1, 1'b1, 32'hFD, 32'h05, 64'hFFF1, -1, "t2_m3x5");
      mul(1, 1'b1, 32'h80, 32'h80, 64'h4000, -1, "t2_m128sq");
      mul(1, 1'b0, 32'hFF, 32'hFF, 64'hFE01, -1, "t2_uffsq");
      mul(1, 1'b1, 32'h7F, 32'h80, 64'hC080, -1, "t2_127xm128");
      mul(0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 10, "t2_m3x5_noet");

      mul(1, 1'b0, 32'h5A, 32'h00, 64'h0000, 3,  "t3_b0");
      mul(1, 1'b0, 32'h7F, 32'h01, 64'h007F, 4,  "t3_b1");
      mul(1, 1'b0, 32'h03, 32'h80, 64'h0180, 10, "t3_b80");
      mul(1, 1'b1, 32'h05, 32'hFF, 64'hFFFB, 4,  "t3_bm1");

      // go while busy is ignored
      start(0, 1'b0, 32'd200, 32'd3);
      tick();
      tick();
      tick();
      set_in(0, 1'b1, 1'b0, 32'd9, 32'd9);
      tick();
      set_in(0, 1'b0, 1'b0, 32'd9, 32'd9);
      get_out(0, bz, dn, pr);
      check("t4_busy_after_go", 64'(bz), 64'd1);
      wait_done(0, 5, cyc, pr);
      check("t4_ignore_prod", pr, 64'h0258);
      check("t4_ignore_cycle", 64'(cyc), 64'd10);
      tick();

      // reset mid-run
      start(0, 1'b0, 32'd13, 32'd11);
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      get_out(0, bz, dn, pr);
      check("t4_rst_busy", 64'(bz), 64'd0);
      check("t4_rst_done", 64'(dn), 64'd0);
      check("t4_rst_prod", pr, 64'h0);
      any_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         get_out(0, bz, dn, pr);
         any_done = any_done | dn | bz;
      end
      check("t4_rst_no_done", 64'(any_done), 64'd0);

      // back-to-back issue from DONE
      start(0, 1'b0, 32'd13, 32'd11);
      wait_done(0, 1, cyc, pr);
      check("t5_first_prod", pr, 64'h008F);
      check("t5_first_cycle", 64'(cyc), 64'd10);
      set_in(0, 1'b1, 1'b0, 32'd6, 32'd7);
      get_out(0, bz, dn, pr);
      check("t5_busy_in_done", 64'(bz), 64'd0);
      tick();
      set_in(0, 1'b0, 1'b0, 32'd6, 32'd7);
      get_out(0, bz, dn, pr);
      check("t5_busy_c1", 64'(bz), 64'd1);
      check("t5_done_c1", 64'(dn), 64'd0);
      check("t5_hold_c1", pr, 64'h008F);
      wait_done(0, 1, cyc, pr);
      check("t5_second_prod", pr, 64'h002A);
      check("t5_second_cycle", 64'(cyc), 64'd10);
      tick();

      mul(2, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 34, "t6_minsq_noet");
      mul(3, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, "t6_minsq_et");
      mul(3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, "t6_umax_et");
      mul(3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, -1, "t6_m1x7_et");
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = i[0];
         if (i % 3 == 2) rb = rb & 32'h0000_03FF;
         if (i % 4 == 3) rb = rb | 32'h8000_0000;
         mul(2, rs, ra, rb, ref64(rs, ra, rb), 34, $sformatf("t6_rand%0d_noet", i));
         mul(3, rs, ra, rb, ref64(rs, ra, rb), -1, $sformatf("t6_rand%0d_et", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
